// File: rtl/video_write_arbiter.sv
// Framebuffer write-port arbiter: CPU pixel stores share the single screen
// buffer write port with a rectangle-fill engine. The CPU wins ties, but a
// streak limiter forces one fill slot after CPU_STREAK_LIMIT back-to-back
// CPU grants, so an active fill always makes progress.
module video_write_arbiter #(
    parameter int SCREEN_WIDTH_BIT_WIDTH  = 8,
    parameter int SCREEN_HEIGHT_BIT_WIDTH = 8,
    parameter int CPU_STREAK_LIMIT        = 4
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic                                                cpu_write,
    input  logic [SCREEN_WIDTH_BIT_WIDTH+SCREEN_HEIGHT_BIT_WIDTH-1:0] cpu_address,
    input  logic [31:0]                                         cpu_data,
    output logic                                                cpu_ready,
    input  logic                                                fill_start,
    input  logic [SCREEN_WIDTH_BIT_WIDTH-1:0]                   fill_x0,
    input  logic [SCREEN_WIDTH_BIT_WIDTH-1:0]                   fill_x1,
    input  logic [SCREEN_HEIGHT_BIT_WIDTH-1:0]                  fill_y0,
    input  logic [SCREEN_HEIGHT_BIT_WIDTH-1:0]                  fill_y1,
    input  logic [23:0]                                         fill_color,
    output logic                                                fill_busy,
    output logic                                                fill_done,
    output logic                                                write,
    output logic [SCREEN_WIDTH_BIT_WIDTH+SCREEN_HEIGHT_BIT_WIDTH-1:0] address,
    output logic [31:0]                                         data
);

    localparam int XW = SCREEN_WIDTH_BIT_WIDTH;
    localparam int YW = SCREEN_HEIGHT_BIT_WIDTH;
    localparam int AW = XW + YW;
    // Streak counter only needs to reach the limit value itself.
    localparam int SW = $clog2(CPU_STREAK_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_STREAK_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   streak_r;
    logic [XW-1:0]   xmin_r;
    logic [XW-1:0]   xmax_r;
    logic [YW-1:0]   ymin_r;
    logic [YW-1:0]   ymax_r;
    logic [XW-1:0]   cur_x_r;
    logic [YW-1:0]   cur_y_r;
    logic [23:0]     color_r;
    logic            write_r;
    logic [AW-1:0]   address_r;
    logic [31:0]     data_r;

    logic            cpu_ready_s;
    logic            cpu_grant_s;
    logic            fill_grant_s;
    logic            last_pixel_s;
    logic            row_end_s;
    logic [XW-1:0]   start_xmin_s;
    logic [XW-1:0]   start_xmax_s;
    logic [YW-1:0]   start_ymin_s;
    logic [YW-1:0]   start_ymax_s;

    // Grant decision and normalisation of the incoming rectangle corners.
    always_comb begin
        cpu_ready_s  = 1'b1;
        cpu_grant_s  = 1'b0;
        fill_grant_s = 1'b0;
        if ((state_r == FILL) && (streak_r == STREAK_MAX)) begin
            cpu_ready_s = 1'b0;
        end else begin
            cpu_ready_s = 1'b1;
        end
        cpu_grant_s = cpu_write && cpu_ready_s;
        if ((state_r == FILL) && !cpu_grant_s) begin
            fill_grant_s = 1'b1;
        end else begin
            fill_grant_s = 1'b0;
        end
        row_end_s    = (cur_x_r == xmax_r);
        last_pixel_s = row_end_s && (cur_y_r == ymax_r);
        if (fill_x0 <= fill_x1) begin
            start_xmin_s = fill_x0;
            start_xmax_s = fill_x1;
        end else begin
            start_xmin_s = fill_x1;
            start_xmax_s = fill_x0;
        end
        if (fill_y0 <= fill_y1) begin
            start_ymin_s = fill_y0;
            start_ymax_s = fill_y1;
        end else begin
            start_ymin_s = fill_y1;
            start_ymax_s = fill_y0;
        end
    end

    // Fill engine FSM: command latch, row-major cursor walk and CPU streak count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= IDLE;
            streak_r <= '0;
            xmin_r   <= '0;
            xmax_r   <= '0;
            ymin_r   <= '0;
            ymax_r   <= '0;
            cur_x_r  <= '0;
            cur_y_r  <= '0;
            color_r  <= 24'h00_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    streak_r <= '0;
                    if (fill_start) begin
                        xmin_r  <= start_xmin_s;
                        xmax_r  <= start_xmax_s;
                        ymin_r  <= start_ymin_s;
                        ymax_r  <= start_ymax_s;
                        cur_x_r <= start_xmin_s;
                        cur_y_r <= start_ymin_s;
                        color_r <= fill_color;
                        state_r <= FILL;
                    end
                end
                FILL: begin
                    // A CPU grant is only possible below the limit, so no overflow.
                    if (cpu_grant_s) begin
                        streak_r <= streak_r + SW'(1'b1);
                    end else begin
                        streak_r <= '0;
                    end
                    if (fill_grant_s) begin
                        if (last_pixel_s) begin
                            state_r <= DONE;
                        end else if (row_end_s) begin
                            cur_x_r <= xmin_r;
                            cur_y_r <= cur_y_r + YW'(1'b1);
                        end else begin
                            cur_x_r <= cur_x_r + XW'(1'b1);
                        end
                    end
                end
                DONE: begin
                    streak_r <= '0;
                    state_r  <= IDLE;
                end
                default: begin
                    streak_r <= '0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Output register: one write per cycle, one cycle after the grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            write_r   <= 1'b0;
            address_r <= '0;
            data_r    <= 32'h0000_0000;
        end else if (cpu_grant_s) begin
            write_r   <= 1'b1;
            address_r <= cpu_address;
            data_r    <= cpu_data;
        end else if (fill_grant_s) begin
            write_r   <= 1'b1;
            address_r <= {cur_y_r, cur_x_r};
            data_r    <= {8'h00, color_r};
        end else begin
            write_r   <= 1'b0;
        end
    end

    assign cpu_ready = cpu_ready_s;
    assign fill_busy = (state_r != IDLE);
    assign fill_done = (state_r == DONE);
    assign write     = write_r;
    assign address   = address_r;
    assign data      = data_r;

endmodule

// File: doc/video_write_arbiter.md
Name: video_write_arbiter

Overview:
- Sole master of the framebuffer write port (write/address/data) of the screen buffer block.
- Shares that port between two requesters:
  - direct CPU pixel stores;
  - a built-in rectangle-fill engine that paints a solid colour over a programmed region, one pixel per cycle.
- CPU traffic has priority. A streak limiter guarantees forward progress for an active fill.

Parameters:
- SCREEN_WIDTH_BIT_WIDTH, 8, x coordinate width (XW).
- SCREEN_HEIGHT_BIT_WIDTH, 8, y coordinate width (YW).
- CPU_STREAK_LIMIT, 4, max consecutive CPU grants while a fill is active before the fill is forced one slot (must be >= 1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- cpu_write  in  1  CPU pixel store request.
- cpu_address  in  XW+YW  CPU pixel address {y,x}.
- cpu_data  in  32  CPU pixel data; passed through unmodified.
- cpu_ready  out  1  combinational; CPU store accepted this cycle when cpu_write && cpu_ready.
- fill_start  in  1  single-cycle fill command strobe.
- fill_x0, fill_x1  in  XW  fill corner x coordinates, sampled with fill_start.
- fill_y0, fill_y1  in  YW  fill corner y coordinates, sampled with fill_start.
- fill_color  in  24  RGB fill colour, sampled with fill_start.
- fill_busy  out  1  high while state != IDLE.
- fill_done  out  1  one-cycle pulse when a fill completes.
- write  out  1  registered write strobe to the screen buffer.
- address  out  XW+YW  registered pixel address, {y,x} (y in the high bits).
- data  out  32  registered pixel data.

Behaviour:
- Reset (reset==0 at a clock edge):
  - write=0, address=0, data=0, fill_busy=0, fill_done=0.
  - State=IDLE; streak counter=0; latched command cleared.
  - Applies mid-fill too: the fill is aborted, with no fill_done and no further writes.
- FSM states: IDLE, FILL, DONE.
  - IDLE: fill_start=1 latches xmin=min(x0,x1), xmax=max(x0,x1), ymin, ymax likewise, and colour. Cursor is set to (xmin,ymin). Go to FILL.
  - FILL: each cycle the fill is granted, it issues cursor pixel with data={8'h00,colour}. Cursor advances row-major: x++; at xmax, x=xmin and y++. Grant of pixel (xmax,ymax) goes to DONE.
  - DONE: fill_done=1 for exactly one cycle, then IDLE.
  - fill_start in FILL or DONE is ignored; the command is not queued.
- Arbitration, per cycle:
  - cpu_ready = !(state==FILL && streak==CPU_STREAK_LIMIT).
  - CPU grant = cpu_write && cpu_ready. The fill is granted in FILL when there is no CPU grant.
  - streak increments on each CPU grant while in FILL, and clears on each fill grant and in IDLE/DONE.
  - cpu_ready is constant 1 outside FILL.
- Output register: on any grant, the next edge loads write=1 and the winner's address/data. Otherwise write=0 and address/data hold their previous value.
  - Latency is exactly 1 cycle from grant to output; at most one write per cycle.
- Timing, no CPU traffic, N-pixel rect, fill_start in cycle 0:
  - FILL in cycles 1..N, write high in cycles 2..N+1.
  - DONE and fill_done in cycle N+1; fill_busy low from cycle N+2.
- Width rules: there is no wrap; coordinates never exceed xmax/ymax. A single-pixel rect (x0==x1, y0==y1) gives 1 write. A full screen gives 2^(XW+YW) writes with no counter overflow (pixel count held in XW+YW+1 bits or derived from the cursor compare).
- cpu_write with cpu_ready=0: no write; the CPU must hold the request.

Test Plan:
- Idle CPU stores: cpu_write with addr 0x1234, data 0xAABBCCDD in cycle 0 -> cycle 1 write=1, address=0x1234, data=0xAABBCCDD; cpu_ready=1 throughout.
- Basic fill: start x0=3,x1=1,y0=2,y1=2,color 0x00FF00 -> writes to 0x0201,0x0202,0x0203 in cycles 2..4, data 0x0000FF00. fill_done pulses in cycle 4; busy low in cycle 5.
- Starvation guard, LIMIT=4: 3x2 fill with continuous cpu_write from cycle 1 -> pattern of 4 CPU writes then 1 fill pixel (cpu_ready low that cycle), repeating. All 6 fill pixels are written and fill_done asserts.
- Single pixel and full screen: 5,5 -> 5,5 gives exactly 1 write. 0,0 -> 255,255 gives exactly 65536 writes, last address 0xFFFF, one fill_done.
- Reset mid-fill: reset=0 at the 10th pixel of a 64-pixel fill -> next cycle write=0, busy=0, no fill_done. A later fill_start runs normally.
- Start while busy: second fill_start during FILL and in the DONE cycle -> ignored; only the first rect's pixels are written.
